// File: rtl/score_tracker_flash.sv
// Score tracker with end-of-game flash.
// Counts the current score from collision pulses, keeps a session high score, and at game end
// holds and flashes the final score for HOLD_CYCLES cycles before the display shows the high score.
// Ports:
//   clk_i              system clock
//   rst_ni             asynchronous active-low reset
//   good_coll_i        one-cycle pulse, food eaten
//   bad_coll_i         one-cycle pulse, wall or self hit
//   clr_high_i         one-cycle pulse, clear high score (IDLE only)
//   disp_score_o       value for the score display
//   disp_blank_o       1 = display must blank (flash off phase)
//   is_game_complete_o 1 from game end until the next game starts
//   new_high_o         1 if the current or last game raised the high score
module score_tracker_flash #(
  parameter int unsigned SCORE_W      = 7,
  parameter int unsigned MAX_SCORE    = 50,
  parameter int unsigned HOLD_CYCLES  = 100000000,
  parameter int unsigned BLINK_CYCLES = 12500000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               good_coll_i,
  input  logic               bad_coll_i,
  input  logic               clr_high_i,
  output logic [SCORE_W-1:0] disp_score_o,
  output logic               disp_blank_o,
  output logic               is_game_complete_o,
  output logic               new_high_o
);

  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_CYCLES + 1);

  localparam logic [SCORE_W-1:0] MaxScore  = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] ScoreOne  = SCORE_W'(1);
  localparam logic [HoldW-1:0]   HoldLast  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [BlinkW-1:0]  BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {StPlay, StHold, StIdle} state_e;

  state_e              state_q, state_d;
  logic [SCORE_W-1:0]  curr_q, curr_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic [SCORE_W-1:0]  final_q, final_d;
  logic [SCORE_W-1:0]  disp_q, disp_d;
  logic                blank_q, blank_d;
  logic                done_q, done_d;
  logic                new_high_q, new_high_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [SCORE_W-1:0]  score_inc;
  logic [SCORE_W-1:0]  high_eff;

  // Saturating increment; PLAY leaves for HOLD before it is ever used at MaxScore.
  assign score_inc = (curr_q >= MaxScore) ? MaxScore : curr_q + ScoreOne;
  // High score as seen by a game start in the same cycle as a clear.
  assign high_eff  = clr_high_i ? '0 : high_q;

  always_comb begin
    state_d     = state_q;
    curr_d      = curr_q;
    high_d      = high_q;
    final_d     = final_q;
    disp_d      = disp_q;
    blank_d     = blank_q;
    done_d      = done_q;
    new_high_d  = new_high_q;
    hold_cnt_d  = hold_cnt_q;
    blink_cnt_d = blink_cnt_q;

    unique case (state_q)
      StPlay: begin
        if (curr_q >= MaxScore || bad_coll_i) begin
          state_d     = StHold;
          final_d     = curr_q;
          curr_d      = '0;
          done_d      = 1'b1;
          disp_d      = curr_q;
          blank_d     = 1'b0;
          hold_cnt_d  = '0;
          blink_cnt_d = '0;
        end else if (good_coll_i) begin
          curr_d = score_inc;
          disp_d = score_inc;
          if (score_inc > high_q) begin
            high_d     = score_inc;
            new_high_d = 1'b1;
          end
        end
      end

      StHold: begin
        disp_d     = final_q;
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_d = '0;
          blank_d     = ~blank_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
          blank_d = 1'b0;
          disp_d  = high_q;
        end
      end

      StIdle: begin
        disp_d  = high_q;
        blank_d = 1'b0;
        if (clr_high_i) begin
          high_d     = '0;
          new_high_d = 1'b0;
          disp_d     = '0;
        end
        if (good_coll_i) begin
          state_d = StPlay;
          curr_d  = ScoreOne;
          done_d  = 1'b0;
          disp_d  = ScoreOne;
          if (ScoreOne > high_eff) begin
            high_d     = ScoreOne;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end
      end

      default: state_d = StPlay;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StPlay;
      curr_q      <= '0;
      high_q      <= '0;
      final_q     <= '0;
      disp_q      <= '0;
      blank_q     <= 1'b0;
      done_q      <= 1'b0;
      new_high_q  <= 1'b0;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      curr_q      <= curr_d;
      high_q      <= high_d;
      final_q     <= final_d;
      disp_q      <= disp_d;
      blank_q     <= blank_d;
      done_q      <= done_d;
      new_high_q  <= new_high_d;
      hold_cnt_q  <= hold_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign disp_score_o       = disp_q;
  assign disp_blank_o       = blank_q;
  assign is_game_complete_o = done_q;
  assign new_high_o         = new_high_q;

endmodule

// File: doc/score_tracker_flash.md
Name: score_tracker_flash

Overview:
- Parametrised successor to the game score tracker.
- Counts the current score from collision pulses and keeps a session high score.
- At game end, holds and flashes the final score for a fixed time before the display falls back to the high score.
- Sits between the collision detector and the score display/7-segment driver. Adds saturation, a new-high flag and a high-score clear.

Parameters:
- SCORE_W, 7, width of all score registers and dispScore.
- MAX_SCORE, 50, score that ends the game. Must satisfy 1 <= MAX_SCORE <= 2**SCORE_W-1.
- HOLD_CYCLES, 100000000, number of cycles spent in HOLD. Must be >= 1.
- BLINK_CYCLES, 12500000, half-period of the flash in cycles. Must be >= 1.

Ports:
- clk, input, 1, system clock.
- nRst, input, 1, reset, asynchronous and active-low.
- goodColl, input, 1, one-cycle pulse: food eaten.
- badColl, input, 1, one-cycle pulse: wall or self hit.
- clrHigh, input, 1, one-cycle pulse: clear the high score (honoured in IDLE only).
- dispScore, output, SCORE_W, value for the score display.
- dispBlank, output, 1, 1 = display driver must blank (flash off phase).
- isGameComplete, output, 1, 1 from game end until the next game starts.
- newHigh, output, 1, 1 if the current or last game raised the high score.

Behaviour:
- Interface: one clock (clk). Reset nRst is asynchronous, active-low. All outputs are registered.
- Reset values: state=PLAY, currScore=0, highScore=0, finalScore=0, dispScore=0, dispBlank=0, isGameComplete=0, newHigh=0, holdCnt=0, blinkCnt=0.
- Latency: an input sampled at edge N is reflected on the outputs after edge N (1-cycle latency).
- States: PLAY, HOLD, IDLE.

PLAY:
- goodColl alone: currScore <= currScore+1, saturating at MAX_SCORE. If the new value > highScore, then highScore <= new value and newHigh <= 1. dispScore <= new currScore.
- badColl (with or without goodColl; badColl wins and the increment is dropped): go to HOLD.
- currScore >= MAX_SCORE at the sampling edge: go to HOLD regardless of inputs. The game therefore ends one cycle after the score reaches MAX_SCORE.
- On entry to HOLD:
  - finalScore <= currScore; currScore <= 0; isGameComplete <= 1.
  - dispScore <= currScore; dispBlank <= 0.
  - holdCnt <= 0; blinkCnt <= 0.
- clrHigh is ignored.

HOLD:
- dispScore = finalScore.
- blinkCnt counts 0..BLINK_CYCLES-1 and wraps. dispBlank toggles on each wrap.
- holdCnt increments every cycle. When holdCnt == HOLD_CYCLES-1: next state IDLE, dispBlank <= 0, dispScore <= highScore. HOLD therefore lasts exactly HOLD_CYCLES cycles.
- goodColl, badColl and clrHigh are ignored.

IDLE:
- dispScore = highScore; dispBlank = 0.
- goodColl: start a new game. State <= PLAY, currScore <= 1, isGameComplete <= 0. newHigh <= 1 if 1 > highScore, else 0. highScore is updated as in PLAY. dispScore <= 1.
- clrHigh alone: highScore <= 0, newHigh <= 0, dispScore <= 0.
- clrHigh together with goodColl: clear first, then start the game. Result: highScore=1, newHigh=1.
- badColl is ignored.

Width rules:
- holdCnt width is clog2(HOLD_CYCLES+1); blinkCnt width is clog2(BLINK_CYCLES+1).
- Score arithmetic is unsigned SCORE_W bits and never wraps (saturation at MAX_SCORE).

Reset mid-operation:
- Asserting nRst in any state returns to the reset values immediately. The high score is not retained.

Test Plan (SCORE_W=4, MAX_SCORE=5, HOLD_CYCLES=8, BLINK_CYCLES=2):
- 3 goodColl pulses then badColl:
  - dispScore goes 1,2,3. newHigh=1.
  - After badColl: isGameComplete=1, dispScore=3 for 8 cycles, dispBlank pattern 0,0,1,1,0,0,1,1.
  - Then IDLE: dispScore=3, dispBlank=0.
- From IDLE with high=3: goodColl, goodColl, badColl:
  - dispScore 1,2 during play, newHigh=0.
  - Flashes 2 during HOLD, then shows 3 in IDLE.
- 5 goodColl pulses with no badColl:
  - dispScore reaches 5; one cycle later HOLD is entered automatically with finalScore=5; highScore=5.
  - Extra goodColl pulses in HOLD are ignored.
- goodColl and badColl in the same PLAY cycle at score 2: score stays 2, HOLD flashes 2, highScore unchanged.
- clrHigh in PLAY and in HOLD: highScore unchanged. clrHigh in IDLE: dispScore=0, newHigh=0 next cycle.
- nRst asserted at holdCnt=4: all outputs return to 0 asynchronously. After release, state is PLAY and highScore=0.
